// File: rtl/scratchpad_dma_loader.sv
// Streaming loader that turns a 32-bit valid/ready/last stream into single-word
// scratchpad backdoor writes, in word mode or INT8 little-endian byte-pack mode.
module scratchpad_dma_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    input  logic                  cfg_byte_mode,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic                  host_mem_we,
    output logic [ADDR_WIDTH-1:0] host_mem_addr,
    output logic [DATA_WIDTH-1:0] host_mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_WIDTH-1:0]  len;
    logic                  byte_mode;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] pack;

    logic                  beat;
    logic                  full_word;
    logic                  word_ready;
    logic                  len_hit;
    logic [CNT_WIDTH-1:0]  next_count;
    logic [DATA_WIDTH-1:0] packed_word;

    // Beat decode: merged byte word (unfilled upper lanes stay zero) and length check
    always_comb begin
        beat        = s_tvalid && s_tready;
        packed_word = pack;
        packed_word[{idx, 3'b000} +: 8] = s_tdata[7:0];
        full_word   = !byte_mode || (idx == 2'd3);
        word_ready  = beat && (full_word || s_tlast);
        next_count  = words_written + CNT_WIDTH'(1);
        len_hit     = (next_count == len) && full_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            base           <= '0;
            len            <= '0;
            byte_mode      <= 1'b0;
            idx            <= 2'd0;
            pack           <= '0;
            s_tready       <= 1'b0;
            host_mem_we    <= 1'b0;
            host_mem_addr  <= '0;
            host_mem_wdata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            words_written  <= '0;
        end else begin
            host_mem_we <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        base          <= cfg_base_addr;
                        len           <= cfg_len;
                        byte_mode     <= cfg_byte_mode;
                        idx           <= 2'd0;
                        pack          <= '0;
                        err           <= 1'b0;
                        words_written <= '0;
                        busy          <= 1'b1;
                        if (cfg_len == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            s_tready <= 1'b0;
                        end else begin
                            state    <= LOAD;
                            s_tready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (word_ready) begin
                        host_mem_we    <= 1'b1;
                        host_mem_addr  <= base + words_written[ADDR_WIDTH-1:0];
                        host_mem_wdata <= byte_mode ? packed_word : s_tdata;
                        words_written  <= next_count;
                        idx            <= 2'd0;
                        pack           <= '0;
                        // s_tready follows the next state so no beat is taken in the closing slot
                        if (s_tlast) begin
                            state    <= DONE;
                            s_tready <= 1'b0;
                            err      <= !len_hit;
                        end else if (len_hit) begin
                            state <= DRAIN;
                            err   <= 1'b1;
                        end
                    end else if (beat) begin
                        pack <= packed_word;
                        idx  <= idx + 2'd1;
                    end
                end
                DRAIN: begin
                    if (beat && s_tlast) begin
                        state    <= DONE;
                        s_tready <= 1'b0;
                    end
                end
                DONE: begin
                    // Hold DONE until the pulse has been shown, so it trails the last write
                    s_tready <= 1'b0;
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    s_tready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
